// File: rtl/poly_mult_pkg.sv
// Shared constants and state encoding for the polynomial multiplier host-side sequencer.
package poly_mult_pkg;

    localparam int CW   = 4;
    localparam int NA   = 2;
    localparam int NB   = 4;
    localparam int NW   = 4;
    localparam int NOPS = NA + NB;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/poly_result_serializer.sv
// Streams the four latched multiplier results out one beat at a time over a valid/ready port.
module poly_result_serializer #(
    parameter int CW = poly_mult_pkg::CW
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_load,
    input  logic [CW-1:0]                     i_first,
    input  logic [poly_mult_pkg::NW*CW-1:0]   i_result,
    input  logic                              i_out_ready,
    output logic                              o_out_valid,
    output logic [CW-1:0]                     o_out_coeff,
    output logic                              o_out_last,
    output logic                              o_done
);
    import poly_mult_pkg::*;

    localparam int IW = $clog2(NW);
    localparam logic [IW-1:0] IDX_LAST = IW'(NW - 1);

    logic [IW-1:0] r_idx;
    logic          r_valid;
    logic          r_last;
    logic [CW-1:0] r_coeff;

    logic          w_take;
    logic [IW-1:0] w_idx_nxt;

    assign w_take    = r_valid && i_out_ready;
    assign w_idx_nxt = r_idx + IW'(1);
    assign o_done    = w_take && r_last;

    // i_first bypasses the latch so w0 is presented on the cycle right after capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_coeff <= '0;
        end else if (i_load) begin
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_coeff <= i_first;
        end else if (w_take) begin
            if (r_last) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_idx   <= w_idx_nxt;
                r_coeff <= i_result[w_idx_nxt*CW +: CW];
                r_last  <= (w_idx_nxt == IDX_LAST);
            end
        end
    end

    assign o_out_valid = r_valid;
    assign o_out_coeff = r_coeff;
    assign o_out_last  = r_last;

endmodule

// File: rtl/poly_mult_io_sequencer.sv
// Host-side sequencer: loads six operand coefficients, runs the multiplier for a fixed
// latency, then streams the four result coefficients back out.
module poly_mult_io_sequencer #(
    parameter int CW           = poly_mult_pkg::CW,
    parameter int MULT_LATENCY = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_coeff,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_coeff,
    output logic          out_last,
    output logic          busy,
    output logic          mult_reset,
    output logic [CW-1:0] data0,
    output logic [CW-1:0] data1,
    output logic [CW-1:0] ddata0,
    output logic [CW-1:0] ddata1,
    output logic [CW-1:0] ddata2,
    output logic [CW-1:0] ddata3,
    input  logic [CW-1:0] w0,
    input  logic [CW-1:0] w1,
    input  logic [CW-1:0] w2,
    input  logic [CW-1:0] w3,
    output logic [1:0]    dbg_state
);
    import poly_mult_pkg::*;

    // Both ports use valid/ready: a beat transfers on a rising edge where valid and ready are
    // both high; valid never waits on ready, and a stalled output beat holds its data.

    localparam logic [7:0] LAT_LAST  = 8'(MULT_LATENCY - 1);
    localparam logic [2:0] BEAT_LAST = 3'(NOPS - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [2:0]               r_beat;
    logic [7:0]               r_lat;
    logic                     r_in_ready;
    logic                     r_busy;
    logic                     r_mult_reset;
    logic [NOPS-1:0][CW-1:0]  r_ops;
    logic [NW*CW-1:0]         r_result;

    logic w_accept;
    logic w_last_beat;
    logic w_run_done;
    logic w_drain_done;
    logic w_in_ready_nxt;
    logic w_busy_nxt;
    logic w_mult_reset_nxt;

    assign w_accept    = in_valid && r_in_ready;
    assign w_last_beat = w_accept && (r_beat == BEAT_LAST);
    assign w_run_done  = (r_state == RUN) && (r_lat == LAT_LAST);

    always_comb begin
        w_state_nxt      = r_state;
        w_in_ready_nxt   = r_in_ready;
        w_busy_nxt       = r_busy;
        w_mult_reset_nxt = r_mult_reset;
        case (r_state)
            LOAD: begin
                if (w_last_beat) begin
                    w_state_nxt      = RUN;
                    w_in_ready_nxt   = 1'b0;
                    w_busy_nxt       = 1'b1;
                    w_mult_reset_nxt = 1'b0;
                end
            end
            RUN: begin
                if (w_run_done) begin
                    w_state_nxt      = DRAIN;
                    w_mult_reset_nxt = 1'b1;
                end
            end
            DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt    = LOAD;
                    w_in_ready_nxt = 1'b1;
                    w_busy_nxt     = 1'b0;
                end
            end
            default: begin
                w_state_nxt      = LOAD;
                w_in_ready_nxt   = 1'b1;
                w_busy_nxt       = 1'b0;
                w_mult_reset_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= LOAD;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b0;
            r_mult_reset <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_in_ready   <= w_in_ready_nxt;
            r_busy       <= w_busy_nxt;
            r_mult_reset <= w_mult_reset_nxt;
        end
    end

    // r_lat is left at zero whenever RUN ends, so each run starts counting from a clean value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat   <= '0;
            r_lat    <= '0;
            r_ops    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_ops[r_beat] <= in_coeff;
                r_beat        <= w_last_beat ? 3'd0 : r_beat + 3'd1;
            end
            if (r_state == RUN) begin
                r_lat <= w_run_done ? 8'd0 : r_lat + 8'd1;
            end
            if (w_run_done) begin
                r_result <= {w3, w2, w1, w0};
            end
        end
    end

    poly_result_serializer #(
        .CW (CW)
    ) u_serializer (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_run_done),
        .i_first     (w0),
        .i_result    (r_result),
        .i_out_ready (out_ready),
        .o_out_valid (out_valid),
        .o_out_coeff (out_coeff),
        .o_out_last  (out_last),
        .o_done      (w_drain_done)
    );

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign mult_reset = r_mult_reset;
    assign data0      = r_ops[0];
    assign data1      = r_ops[1];
    assign ddata0     = r_ops[2];
    assign ddata1     = r_ops[3];
    assign ddata2     = r_ops[4];
    assign ddata3     = r_ops[5];
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_poly_mult_io_sequencer.sv
// Bench for poly_mult_io_sequencer: table-driven operations, random traffic against a
// cycle-timed reference model, reset in mid-run, and a MULT_LATENCY=1 instance.
module tb_poly_mult_io_sequencer;
    import poly_mult_pkg::*;

    localparam int L  = 8;
    localparam int LE = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // main instance (MULT_LATENCY = 8)
    logic       in_valid, in_ready, out_valid, out_ready, out_last, busy, mult_reset;
    logic [3:0] in_coeff, out_coeff, data0, data1, ddata0, ddata1, ddata2, ddata3;
    logic [3:0] stub_w0, stub_w1, stub_w2, stub_w3;
    logic [1:0] dbg_state;

    // edge instance (MULT_LATENCY = 1)
    logic       e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_out_last, e_busy, e_mult_reset;
    logic [3:0] e_in_coeff, e_out_coeff, e_data0, e_data1, e_ddata0, e_ddata1, e_ddata2, e_ddata3;
    logic [3:0] e_w0, e_w1, e_w2, e_w3;
    logic [1:0] e_dbg_state;

    poly_mult_io_sequencer #(.CW(4), .MULT_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_coeff(in_coeff),
        .out_valid(out_valid), .out_ready(out_ready), .out_coeff(out_coeff), .out_last(out_last),
        .busy(busy), .mult_reset(mult_reset),
        .data0(data0), .data1(data1), .ddata0(ddata0), .ddata1(ddata1), .ddata2(ddata2), .ddata3(ddata3),
        .w0(stub_w0), .w1(stub_w1), .w2(stub_w2), .w3(stub_w3),
        .dbg_state(dbg_state)
    );

    poly_mult_io_sequencer #(.CW(4), .MULT_LATENCY(LE)) dut_edge (
        .clk(clk), .reset(reset),
        .in_valid(e_in_valid), .in_ready(e_in_ready), .in_coeff(e_in_coeff),
        .out_valid(e_out_valid), .out_ready(e_out_ready), .out_coeff(e_out_coeff), .out_last(e_out_last),
        .busy(e_busy), .mult_reset(e_mult_reset),
        .data0(e_data0), .data1(e_data1), .ddata0(e_ddata0), .ddata1(e_ddata1), .ddata2(e_ddata2), .ddata3(e_ddata3),
        .w0(e_w0), .w1(e_w1), .w2(e_w2), .w3(e_w3),
        .dbg_state(e_dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] dut_op(input int i);
        case (i)
            0: return data0;
            1: return data1;
            2: return ddata0;
            3: return ddata1;
            4: return ddata2;
            default: return ddata3;
        endcase
    endfunction

    function automatic logic [3:0] edge_op(input int i);
        case (i)
            0: return e_data0;
            1: return e_data1;
            2: return e_ddata0;
            3: return e_ddata1;
            4: return e_ddata2;
            default: return e_ddata3;
        endcase
    endfunction

    function automatic logic [5:0][3:0] pack6(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                                              input logic [3:0] d, input logic [3:0] e, input logic [3:0] f);
        logic [5:0][3:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f;
        return r;
    endfunction

    function automatic logic [3:0][3:0] pack4(input logic [3:0] a, input logic [3:0] b,
                                              input logic [3:0] c, input logic [3:0] d);
        logic [3:0][3:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    // ---------------- reference model / scoreboard ----------------
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]  exp_q[$];
    logic [3:0]  got_q[$];
    logic [3:0]  e_ops[6];
    int          nb = 0;
    bit          active = 1'b0;
    bit          captured = 1'b0;
    int unsigned t6 = 0;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            active = 1'b0;
            captured = 1'b0;
            nb = 0;
            exp_q.delete();
            for (int i = 0; i < 6; i++) e_ops[i] = 4'h0;
            chk("rst_in_ready", 8'(in_ready), 8'd1);
            chk("rst_busy", 8'(busy), 8'd0);
            chk("rst_mult_reset", 8'(mult_reset), 8'd1);
            chk("rst_out_valid", 8'(out_valid), 8'd0);
            chk("rst_out_last", 8'(out_last), 8'd0);
            chk("rst_out_coeff", 8'(out_coeff), 8'd0);
            chk("rst_state", 8'(dbg_state), 8'(LOAD));
            for (int i = 0; i < 6; i++) chk($sformatf("rst_operand%0d", i), 8'(dut_op(i)), 8'd0);
        end else begin
            chk("in_ready", 8'(in_ready), 8'(!active));
            chk("busy", 8'(busy), 8'(active));
            chk("mult_reset", 8'(mult_reset), 8'(!(active && !captured)));
            chk("out_valid", 8'(out_valid), 8'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("out_coeff", 8'(out_coeff), 8'(exp_q[0]));
                chk("out_last", 8'(out_last), 8'(exp_q.size() == 1));
            end
            for (int i = 0; i < 6; i++) chk($sformatf("operand%0d", i), 8'(dut_op(i)), 8'(e_ops[i]));
            if (in_valid && !active) begin
                e_ops[nb] = in_coeff;
                nb++;
                if (nb == 6) begin
                    nb = 0;
                    active = 1'b1;
                    captured = 1'b0;
                    t6 = cyc;
                end
            end else if (active && !captured && cyc == t6 + L) begin
                exp_q.push_back(stub_w0);
                exp_q.push_back(stub_w1);
                exp_q.push_back(stub_w2);
                exp_q.push_back(stub_w3);
                captured = 1'b1;
            end else if (exp_q.size() != 0 && out_ready) begin
                got_q.push_back(out_coeff);
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    active = 1'b0;
                    captured = 1'b0;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    logic [1:0] rdy_mode = 2'd0;
    bit         w_rand = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            2'd0:    out_ready = 1'b1;
            2'd1:    out_ready = !out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (w_rand) begin
            stub_w0 = 4'($urandom);
            stub_w1 = 4'($urandom);
            stub_w2 = 4'($urandom);
            stub_w3 = 4'($urandom);
        end
    end

    task automatic send_op(input logic [5:0][3:0] c, input int gap_max);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_coeff = c[i];
            @(posedge clk);
            #1;
        end
    endtask

    // Keeps junk (value 15) on the input while busy, releasing it as soon as in_ready returns.
    task automatic wait_done();
        int budget;
        budget = 0;
        while (!in_ready && budget < 400) begin
            in_valid = 1'b1;
            in_coeff = 4'hF;
            @(posedge clk);
            #1;
            budget++;
        end
        in_valid = 1'b0;
        chk("done_timeout", 8'(budget < 400), 8'd1);
    endtask

    typedef struct packed {
        logic [5:0][3:0] c;
        logic [3:0][3:0] w;
        logic [5:0][3:0] exp_ops;
        logic [3:0][3:0] exp_out;
        logic [1:0]      rdy_mode;
        logic [1:0]      gap;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        logic [5:0][3:0] rc;
        logic [3:0][3:0] ew;

        vecs[0] = '{pack6(4'h8, 4'h0, 4'h5, 4'h6, 4'h8, 4'h0), pack4(4'h1, 4'h2, 4'h3, 4'h4),
                    pack6(4'h8, 4'h0, 4'h5, 4'h6, 4'h8, 4'h0), pack4(4'h1, 4'h2, 4'h3, 4'h4), 2'd0, 2'd0};
        vecs[1] = '{pack6(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6), pack4(4'hF, 4'hE, 4'hD, 4'hC),
                    pack6(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6), pack4(4'hF, 4'hE, 4'hD, 4'hC), 2'd1, 2'd2};
        vecs[2] = '{pack6(4'hF, 4'hF, 4'h0, 4'h0, 4'hA, 4'h5), pack4(4'h0, 4'h0, 4'h0, 4'h0),
                    pack6(4'hF, 4'hF, 4'h0, 4'h0, 4'hA, 4'h5), pack4(4'h0, 4'h0, 4'h0, 4'h0), 2'd2, 2'd1};
        vecs[3] = '{pack6(4'h3, 4'hC, 4'h7, 4'h9, 4'h2, 4'hB), pack4(4'h9, 4'h8, 4'h7, 4'h6),
                    pack6(4'h3, 4'hC, 4'h7, 4'h9, 4'h2, 4'hB), pack4(4'h9, 4'h8, 4'h7, 4'h6), 2'd1, 2'd0};

        reset = 1'b0;
        in_valid = 1'b0;
        in_coeff = 4'h0;
        out_ready = 1'b0;
        {stub_w3, stub_w2, stub_w1, stub_w0} = 16'h0;
        e_in_valid = 1'b0;
        e_in_coeff = 4'h0;
        e_out_ready = 1'b0;
        {e_w3, e_w2, e_w1, e_w0} = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // table-driven operations
        for (int r = 0; r < 4; r++) begin
            w_rand = 1'b0;
            rdy_mode = vecs[r].rdy_mode;
            {stub_w3, stub_w2, stub_w1, stub_w0} = vecs[r].w;
            got_q.delete();
            send_op(vecs[r].c, int'(vecs[r].gap));
            for (int i = 0; i < 6; i++)
                chk($sformatf("vec%0d_op%0d", r, i), 8'(dut_op(i)), 8'(vecs[r].exp_ops[i]));
            wait_done();
            chk($sformatf("vec%0d_count", r), 8'(got_q.size()), 8'd4);
            for (int i = 0; i < 4 && i < got_q.size(); i++)
                chk($sformatf("vec%0d_out%0d", r, i), 8'(got_q[i]), 8'(vecs[r].exp_out[i]));
        end

        // random operations with w changing every cycle
        for (int k = 0; k < 20; k++) begin
            w_rand = 1'b1;
            rdy_mode = 2'($urandom_range(0, 2));
            rc = 24'($urandom);
            got_q.delete();
            send_op(rc, 3);
            wait_done();
            chk($sformatf("rand%0d_count", k), 8'(got_q.size()), 8'd4);
        end

        // reset in the third RUN cycle
        w_rand = 1'b0;
        rdy_mode = 2'd0;
        send_op(24'($urandom), 0);
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        chk("midrun_mult_reset", 8'(mult_reset), 8'd1);
        chk("midrun_in_ready", 8'(in_ready), 8'd1);
        chk("midrun_out_valid", 8'(out_valid), 8'd0);
        chk("midrun_busy", 8'(busy), 8'd0);
        for (int i = 0; i < 6; i++) chk($sformatf("midrun_op%0d", i), 8'(dut_op(i)), 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        got_q.delete();
        send_op(24'($urandom), 1);
        wait_done();
        chk("recover_count", 8'(got_q.size()), 8'd4);

        // MULT_LATENCY = 1 instance
        ew = 16'($urandom);
        {e_w3, e_w2, e_w1, e_w0} = ew;
        rc = 24'($urandom);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("edge_in_ready%0d", i), 8'(e_in_ready), 8'd1);
            e_in_valid = 1'b1;
            e_in_coeff = rc[i];
            @(posedge clk);
            #1;
        end
        e_in_valid = 1'b0;
        chk("edge_run_mult_reset", 8'(e_mult_reset), 8'd0);
        chk("edge_run_busy", 8'(e_busy), 8'd1);
        chk("edge_run_in_ready", 8'(e_in_ready), 8'd0);
        chk("edge_run_out_valid", 8'(e_out_valid), 8'd0);
        for (int i = 0; i < 6; i++) chk($sformatf("edge_op%0d", i), 8'(edge_op(i)), 8'(rc[i]));
        @(posedge clk);
        #1;
        {e_w3, e_w2, e_w1, e_w0} = ~ew;
        chk("edge_mult_reset_back", 8'(e_mult_reset), 8'd1);
        e_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("edge_out_valid%0d", k), 8'(e_out_valid), 8'd1);
            chk($sformatf("edge_out_coeff%0d", k), 8'(e_out_coeff), 8'(ew[k]));
            chk($sformatf("edge_out_last%0d", k), 8'(e_out_last), 8'(k == 3));
            @(posedge clk);
            #1;
        end
        e_out_ready = 1'b0;
        chk("edge_end_out_valid", 8'(e_out_valid), 8'd0);
        chk("edge_end_in_ready", 8'(e_in_ready), 8'd1);
        chk("edge_end_busy", 8'(e_busy), 8'd0);
        chk("edge_end_state", 8'(e_dbg_state), 8'(LOAD));

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/poly_mult_io_sequencer.md
Name: poly_mult_io_sequencer

Overview:
- Host-side end of the polynomial multiplier's operand/result interface.
- Accepts a valid/ready stream of 4-bit coefficients, assembles them into the parallel operand ports (data0..data1, ddata0..ddata3), and drives the multiplier's active-high reset to launch a computation.
- After a fixed latency it captures w0..w3 and streams them back out on a valid/ready port.

Parameters:
- CW, 4: coefficient width in bits.
- MULT_LATENCY, 8: cycles mult_reset is held low before w0..w3 are captured; legal range 1..255.

Ports:
- clk, input, 1: clock; all logic is rising-edge.
- reset, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: in_coeff is valid.
- in_ready, output, 1: sequencer accepts a coefficient this cycle.
- in_coeff, input, CW: operand coefficient.
- out_valid, output, 1: out_coeff is valid.
- out_ready, input, 1: consumer accepts a result coefficient.
- out_coeff, output, CW: result coefficient.
- out_last, output, 1: high with the w3 beat.
- busy, output, 1: high in RUN and DRAIN.
- mult_reset, output, 1: active-high reset to the multiplier.
- data0, output, CW: multiplier operand; same for data1.
- ddata0, output, CW: multiplier operand; same for ddata1, ddata2, ddata3.
- w0, input, CW: multiplier result; same for w1, w2, w3.

Behaviour:
- Reset values (reset low, asynchronous):
  - state=LOAD, beat count=0.
  - in_ready=1, out_valid=0, out_last=0, busy=0.
  - mult_reset=1, out_coeff=0, all operand registers=0.
- All outputs are registered.
- FSM states LOAD, RUN, DRAIN.
- LOAD:
  - in_ready=1 and mult_reset=1.
  - Each in_valid&&in_ready beat writes one operand register, in order data0, data1, ddata0, ddata1, ddata2, ddata3.
  - A beat only updates its own register; the other operand registers hold their previous values.
  - On the 6th accepted beat: next state is RUN, in_ready=0, busy=1.
  - in_valid is ignored whenever in_ready=0.
- RUN:
  - mult_reset=0 for exactly MULT_LATENCY cycles, starting the cycle after the 6th beat.
  - Operands are stable throughout RUN.
  - On the edge ending the MULT_LATENCY-th cycle:
    - w0..w3 are latched into a 4-entry result register.
    - mult_reset returns to 1.
    - State moves to DRAIN; out_valid=1 and out_coeff=w0 on the next cycle.
- DRAIN:
  - Each out_valid&&out_ready beat advances w0, w1, w2, w3; out_last=1 only while presenting w3.
  - While out_valid&&!out_ready, out_coeff and out_last are held stable.
  - After the w3 beat is accepted: out_valid=0, busy=0, in_ready=1 next cycle, state=LOAD.
- Latency: from the 6th input beat to the first out_valid is MULT_LATENCY+1 cycles.
- Back-to-back operation: input is not accepted during RUN or DRAIN (no overlap).
- Reset mid-operation: immediate return to reset values.
  - Any partial load or pending result is discarded.
  - mult_reset goes high asynchronously.
- Result latching is unconditional; w values are captured as-is and carry no validity check.
- Counters:
  - Beat counter is 3 bits and does not wrap past 5.
  - Latency counter is 8 bits; the RUN length is exact for every legal MULT_LATENCY.

Decomposition:
- Package poly_mult_pkg holds:
  - CW;
  - operand counts NA=2, NB=4, NW=4;
  - the state encoding LOAD/RUN/DRAIN.
- One natural sub-module: poly_result_serializer. It takes the 4-entry latch plus the out handshake and provides out_valid, out_last and a done pulse.

Test Plan:
- Basic load:
  - Stimulus: reset low 2 cycles, then in_valid continuously with 8,0,5,6,8,0.
  - Required response: data0=8, data1=0, ddata0=5, ddata1=6, ddata2=8, ddata3=0.
  - in_ready falls after beat 6; mult_reset is low exactly 8 cycles.
- Result drain:
  - Stimulus: stub drives w=1,2,3,4; out_ready=1.
  - Required response: out_coeff sequence 1,2,3,4 on consecutive cycles; out_last only on 4.
  - First out_valid arrives 9 cycles after beat 6; in_ready=1 on the cycle after the last beat.
- Backpressure:
  - Stimulus: out_ready toggles 0/1 every cycle; in_valid pulses with gaps.
  - Required response: no coefficient dropped or duplicated; out_coeff is stable while stalled.
  - Operand registers are written only on handshake beats.
- Input ignored when busy:
  - Stimulus: in_valid=1 with value 15 throughout RUN and DRAIN.
  - Required response: operand registers are unchanged.
  - The next load begins only after the w3 beat is accepted.
- Reset mid-RUN:
  - Stimulus: reset low at RUN cycle 3.
  - Required response: mult_reset=1 and in_ready=1 immediately; out_valid=0; all operands read 0.
- Parameter edge:
  - Stimulus: MULT_LATENCY=1.
  - Required response: mult_reset is low for exactly 1 cycle; first out_valid arrives 2 cycles after beat 6.
